// File: rtl/segway_auth_pkg.sv
// Shared types and default constants for the Segway power-up authorisation front end.
package segway_auth_pkg;

    typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int         DEF_BAUD_DIV = 2604;   // 50 MHz / 19200 baud
    localparam logic [7:0] DEF_CMD_GO   = 8'h47;  // 'G'
    localparam logic [7:0] DEF_CMD_STOP = 8'h53;  // 'S'

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, falling-edge start detect, mid-bit sampling.
//
// Output handshake: rx_rdy is a single-cycle valid strobe with no ready/back-pressure;
// rx_data is valid on and after the rx_rdy cycle and holds until the next good byte.
// frame_err is a single-cycle strobe for a byte whose stop bit was low; that byte is
// dropped and rx_data keeps its previous value.
module uart_rx_core
    import segway_auth_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    output logic       frame_err
);

    localparam logic [15:0] HALF_LOAD = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(BAUD_DIV - 1);

    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    logic [1:0]  fill;
    rx_state_t   state;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;

    // Synchronise RX; rx_prev only follows real line data once the reset value of the
    // synchroniser has been flushed, so a line held low at reset release never looks
    // like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b0;
            fill    <= 2'd0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            if (fill != 2'd2)
                fill <= fill + 2'd1;
            rx_prev <= (fill == 2'd2) ? rx_s2 : 1'b0;
        end
    end

    // Receiver FSM: start qualify at half bit, then one sample per bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        state    <= START;
                        baud_cnt <= HALF_LOAD;
                        bit_cnt  <= 4'd0;
                    end
                end
                START: begin
                    if (baud_cnt != 16'd0) begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end else if (rx_s2) begin
                        state <= IDLE;  // glitch, not a real start bit
                    end else begin
                        state    <= DATA;
                        baud_cnt <= FULL_LOAD;
                    end
                end
                DATA: begin
                    if (baud_cnt != 16'd0) begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end else begin
                        shift    <= {rx_s2, shift[7:1]};
                        bit_cnt  <= bit_cnt + 4'd1;
                        baud_cnt <= FULL_LOAD;
                        if (bit_cnt == 4'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (baud_cnt != 16'd0) begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end else begin
                        if (rx_s2) begin
                            rx_data <= shift;
                            rx_rdy  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/auth_cmd_rx.sv
// Segway power-up authorisation: UART 'G'/'S' commands combined with rider_off.
module auth_cmd_rx
    import segway_auth_pkg::*;
#(
    parameter int         BAUD_DIV = DEF_BAUD_DIV,
    parameter logic [7:0] CMD_GO   = DEF_CMD_GO,
    parameter logic [7:0] CMD_STOP = DEF_CMD_STOP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    output logic       frame_err
);

    auth_state_t state;

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .frame_err (frame_err)
    );

    // Auth FSM; pwr_up is registered alongside the state and always equals (state != OFF).
    // In PWR1 the rider may step off while rolling, so only an 'S' can leave it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= OFF;
            pwr_up <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (rx_rdy && rx_data == CMD_GO) begin
                        state  <= PWR1;
                        pwr_up <= 1'b1;
                    end
                end
                PWR1: begin
                    if (rx_rdy && rx_data == CMD_STOP) begin
                        if (rider_off) begin
                            state  <= OFF;
                            pwr_up <= 1'b0;
                        end else begin
                            state <= PWR2;
                        end
                    end
                end
                PWR2: begin
                    if (rider_off) begin
                        state  <= OFF;
                        pwr_up <= 1'b0;
                    end else if (rx_rdy && rx_data == CMD_GO) begin
                        state <= PWR1;
                    end
                end
                default: begin
                    state  <= OFF;
                    pwr_up <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_auth_cmd_rx.sv
// Directed bench for auth_cmd_rx with a UART tx model and a received-byte scoreboard.
module tb_auth_cmd_rx;

    // Reduced bit period keeps the run short; latency window follows 9.5*B + 3 (+0..4).
    localparam int BAUD    = 160;
    localparam int LAT_MIN = (19 * BAUD) / 2 + 3;
    localparam int LAT_MAX = LAT_MIN + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b0;
    logic       rider_off = 1'b0;
    logic       pwr_up;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int start_cyc = 0;
    int last_rdy_cyc = 0;
    int rdy_cycles = 0;
    int ferr_cycles = 0;
    bit pend_pwr = 1'b0;

    logic [7:0] exp_q[$];
    logic       pwr_log[$];

    auth_cmd_rx #(
        .BAUD_DIV (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .rider_off (rider_off),
        .pwr_up    (pwr_up),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .frame_err (frame_err)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // UART tx model: start bit, 8 data bits LSB first, stop bit of the given level
    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1;
        RX = 1'b0;
        start_cyc = cyc;
        repeat (BAUD) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            RX = b[i];
            repeat (BAUD) @(posedge clk);
        end
        #1;
        RX = stop_bit;
        repeat (BAUD) @(posedge clk);
        #1;
        RX = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // scoreboard / monitor: compare each rx_rdy byte against exp_q, log pwr_up one cycle later
    always @(negedge clk) begin
        if (pend_pwr) begin
            pwr_log.push_back(pwr_up);
            pend_pwr = 1'b0;
        end
        if (rx_rdy === 1'b1) begin
            rdy_cycles++;
            last_rdy_cyc = cyc;
            pend_pwr = 1'b1;
            if (exp_q.size() == 0)
                check("rdy_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else
                check("rx_data_sb", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (frame_err === 1'b1)
            ferr_cycles++;
    end

    // watchdog
    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int rdy0;
        int ferr0;

        // 1: reset with RX low, release, then line goes idle-high
        rst = 1'b1;
        RX = 1'b0;
        idle(50);
        check("rst_pwr_up", 32'(pwr_up), 0);
        check("rst_rx_rdy", 32'(rx_rdy), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        rst = 1'b0;
        idle(10);
        RX = 1'b1;
        idle(20);
        check("t1_pwr_up", 32'(pwr_up), 0);
        check("t1_rdy_cycles", 32'(rdy_cycles), 0);
        check("t1_ferr_cycles", 32'(ferr_cycles), 0);

        // 2: 'G' -> rx_rdy in the latency window, pwr_up one cycle later
        pwr_log.delete();
        exp_q.push_back(8'h47);
        uart_send(8'h47, 1'b1);
        idle(5);
        lat = last_rdy_cyc - start_cyc;
        $display("info: G latency %0d cycles (window %0d..%0d)", lat, LAT_MIN, LAT_MAX);
        check("t2_latency_in_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
        check("t2_rdy_cycles", 32'(rdy_cycles), 1);
        check("t2_pwr_log_size", 32'(pwr_log.size()), 1);
        if (pwr_log.size() >= 1)
            check("t2_pwr_after_rdy", 32'(pwr_log[0]), 1);
        check("t2_pwr_up", 32'(pwr_up), 1);

        // 3: rider_off alone in PWR1 keeps power; 'S' with rider on -> PWR2; rider_off -> OFF
        rider_off = 1'b1;
        idle(8);
        check("t3_pwr1_rider_off", 32'(pwr_up), 1);
        rider_off = 1'b0;
        exp_q.push_back(8'h53);
        uart_send(8'h53, 1'b1);
        idle(5);
        check("t3_pwr2_after_s", 32'(pwr_up), 1);
        @(posedge clk);
        #1;
        rider_off = 1'b1;
        @(negedge clk);
        check("t3_pwr2_before_edge", 32'(pwr_up), 1);
        @(negedge clk);
        check("t3_pwr2_rider_off", 32'(pwr_up), 0);

        // 4: unknown byte while OFF, then 'G','S' back-to-back with rider_off=1
        exp_q.push_back(8'h41);
        uart_send(8'h41, 1'b1);
        idle(5);
        check("t4_rx_data_41", 32'(rx_data), 32'h41);
        check("t4_pwr_off_41", 32'(pwr_up), 0);
        rdy0 = rdy_cycles;
        pwr_log.delete();
        exp_q.push_back(8'h47);
        exp_q.push_back(8'h53);
        uart_send(8'h47, 1'b1);
        uart_send(8'h53, 1'b1);
        idle(5);
        check("t4_two_rdy", 32'(rdy_cycles - rdy0), 2);
        check("t4_pwr_log_size", 32'(pwr_log.size()), 2);
        if (pwr_log.size() == 2) begin
            check("t4_pwr_after_g", 32'(pwr_log[0]), 1);
            check("t4_pwr_after_s", 32'(pwr_log[1]), 0);
        end
        check("t4_pwr_final", 32'(pwr_up), 0);

        // 5: 'G' with stop bit low -> one-cycle frame_err, byte dropped
        rdy0 = rdy_cycles;
        ferr0 = ferr_cycles;
        uart_send(8'h47, 1'b0);
        idle(2 * BAUD);
        check("t5_ferr_one_cycle", 32'(ferr_cycles - ferr0), 1);
        check("t5_no_rdy", 32'(rdy_cycles - rdy0), 0);
        check("t5_rx_data_held", 32'(rx_data), 32'h53);
        check("t5_pwr_off", 32'(pwr_up), 0);

        // power up again so the mid-frame reset has something to clear
        rider_off = 1'b0;
        exp_q.push_back(8'h47);
        uart_send(8'h47, 1'b1);
        idle(5);
        check("t6_pre_pwr_up", 32'(pwr_up), 1);

        // 6: reset during data bit 4 of a 'G' frame
        rdy0 = rdy_cycles;
        ferr0 = ferr_cycles;
        fork
            uart_send(8'h47, 1'b1);
            begin
                repeat (5 * BAUD + BAUD / 2) @(posedge clk);
                #2;
                rst = 1'b1;
                #1;
                check("t6_rst_pwr_up", 32'(pwr_up), 0);
                check("t6_rst_rx_rdy", 32'(rx_rdy), 0);
                check("t6_rst_rx_data", 32'(rx_data), 0);
                check("t6_rst_frame_err", 32'(frame_err), 0);
            end
        join
        idle(5);
        rst = 1'b0;
        idle(20);
        check("t6_abort_no_rdy", 32'(rdy_cycles - rdy0), 0);
        check("t6_abort_no_ferr", 32'(ferr_cycles - ferr0), 0);
        exp_q.push_back(8'h47);
        uart_send(8'h47, 1'b1);
        idle(5);
        check("t6_rdy_after_rst", 32'(rdy_cycles - rdy0), 1);
        check("t6_pwr_up_after_g", 32'(pwr_up), 1);

        // quarter-bit low glitch is rejected at the start-bit check
        rdy0 = rdy_cycles;
        ferr0 = ferr_cycles;
        @(posedge clk);
        #1;
        RX = 1'b0;
        repeat (BAUD / 4) @(posedge clk);
        #1;
        RX = 1'b1;
        idle(12 * BAUD);
        check("t6_glitch_no_rdy", 32'(rdy_cycles - rdy0), 0);
        check("t6_glitch_no_ferr", 32'(ferr_cycles - ferr0), 0);
        check("t6_glitch_pwr_hold", 32'(pwr_up), 1);

        check("exp_q_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
